// File: rtl/wbu_gpr_pkg.sv
// Shared encodings for the write-back stage: write-back ops, branch
// conditions and the compare codes produced by the EXU.
package wbu_gpr_pkg;

  typedef enum logic [1:0] {
    WB_PASS   = 2'd0,
    WB_SLT    = 2'd1,
    WB_BRANCH = 2'd2,
    WB_NONE   = 2'd3
  } wb_op_e;

  typedef enum logic [2:0] {
    BR_EQ = 3'd0,
    BR_NE = 3'd1,
    BR_LT = 3'd4,
    BR_GE = 3'd5
  } br_cond_e;

  localparam logic [31:0] CMP_EQ = 32'h0000_0000;
  localparam logic [31:0] CMP_GT = 32'h0000_0002;
  localparam logic [31:0] CMP_LT = 32'h0000_0004;

  // Branch decision from the EXU compare code; unknown conditions are not taken.
  function automatic logic branch_taken(input logic [2:0] cond, input logic [31:0] cmp);
    logic taken;
    case (cond)
      BR_EQ:   taken = (cmp == CMP_EQ);
      BR_NE:   taken = (cmp != CMP_EQ);
      BR_LT:   taken = (cmp == CMP_LT);
      BR_GE:   taken = (cmp != CMP_LT);
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/wbu_gpr_if.sv
// Bus between the EXU/fetch side and the write-back stage with its GPR ports.
interface wbu_gpr_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] exu_data;
  logic [1:0]  wb_op;
  logic [2:0]  br_cond;
  logic [4:0]  rd;
  logic        wen;
  logic [31:0] pc;
  logic [31:0] imm;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] next_pc;
  logic        br_taken;

  modport slave (
    input  in_valid, exu_data, wb_op, br_cond, rd, wen, pc, imm,
    input  raddr1, raddr2, out_ready,
    output in_ready, rdata1, rdata2, out_valid, next_pc, br_taken
  );

  modport master (
    output in_valid, exu_data, wb_op, br_cond, rd, wen, pc, imm,
    output raddr1, raddr2, out_ready,
    input  in_ready, rdata1, rdata2, out_valid, next_pc, br_taken
  );
endinterface

// File: rtl/wbu_gpr_gpr_file.sv
// Architectural register file: two combinational read ports, one
// synchronous write port, x0 and out-of-range indices read as zero.
module gpr_file #(
  parameter int NR_REG = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2
);
  localparam logic [5:0] NR_W = 6'(NR_REG);

  logic [31:0] r_mem [0:NR_REG-1];
  logic        w_wr_ok;

  assign w_wr_ok = i_we && (i_waddr != 5'd0) && ({1'b0, i_waddr} < NR_W);

  // Storage update: clear everything on reset, otherwise single write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NR_REG; i++) begin
        r_mem[i] <= 32'h0;
      end
    end else if (w_wr_ok) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Zero-latency reads with x0 and out-of-range indices forced to zero.
  always_comb begin
    o_rdata1 = 32'h0;
    o_rdata2 = 32'h0;
    if ((i_raddr1 != 5'd0) && ({1'b0, i_raddr1} < NR_W)) o_rdata1 = r_mem[i_raddr1];
    else o_rdata1 = 32'h0;
    if ((i_raddr2 != 5'd0) && ({1'b0, i_raddr2} < NR_W)) o_rdata2 = r_mem[i_raddr2];
    else o_rdata2 = 32'h0;
  end
endmodule

// File: rtl/wbu_gpr.sv
// Write-back stage: one-entry result register feeding the GPR file and
// the next-PC computation, with forwarding of the pending write.
module wbu_gpr
  import wbu_gpr_pkg::*;
#(
  parameter int NR_REG = 32
) (
  input logic      clk,
  input logic      rst_n,
  wbu_gpr_if.slave bus
);
  localparam logic [5:0] NR_W = 6'(NR_REG);

  logic        r_busy;
  logic        r_wr_pend;
  logic [4:0]  r_rd;
  logic [31:0] r_wdata;
  logic [31:0] r_next_pc;
  logic        r_br_taken;

  logic        w_accept;
  logic        w_commit;
  logic        w_taken;
  logic        w_wr_req;
  logic [31:0] w_wdata;
  logic [31:0] w_next_pc;
  logic [31:0] w_gpr_rd1;
  logic [31:0] w_gpr_rd2;

  assign bus.in_ready  = !r_busy || bus.out_ready;
  assign bus.out_valid = r_busy;
  assign bus.next_pc   = r_next_pc;
  assign bus.br_taken  = r_br_taken;
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign w_commit      = r_busy && bus.out_ready;

  // Decode the incoming result: write data, write qualification, branch target.
  // Target and write data are resolved here so the stage only holds results.
  always_comb begin
    w_wdata   = bus.exu_data;
    w_wr_req  = 1'b0;
    w_taken   = 1'b0;
    case (bus.wb_op)
      WB_PASS:   w_wdata = bus.exu_data;
      WB_SLT:    w_wdata = {31'b0, (bus.exu_data == CMP_LT)};
      WB_BRANCH: w_taken = branch_taken(bus.br_cond, bus.exu_data);
      default:   w_wdata = bus.exu_data;
    endcase
    if (bus.wen && (bus.rd != 5'd0) && ({1'b0, bus.rd} < NR_W) &&
        ((bus.wb_op == WB_PASS) || (bus.wb_op == WB_SLT))) w_wr_req = 1'b1;
    else w_wr_req = 1'b0;
    if (w_taken) w_next_pc = bus.pc + bus.imm;
    else w_next_pc = bus.pc + 32'd4;
  end

  // Stage register: load on accept, drain on commit, hold while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy     <= 1'b0;
      r_wr_pend  <= 1'b0;
      r_rd       <= 5'd0;
      r_wdata    <= 32'h0;
      r_next_pc  <= 32'h0;
      r_br_taken <= 1'b0;
    end else if (w_accept) begin
      r_busy     <= 1'b1;
      r_wr_pend  <= w_wr_req;
      r_rd       <= bus.rd;
      r_wdata    <= w_wdata;
      r_next_pc  <= w_next_pc;
      r_br_taken <= w_taken;
    end else if (w_commit) begin
      r_busy     <= 1'b0;
    end
  end

  gpr_file #(.NR_REG(NR_REG)) u_gpr_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_commit && r_wr_pend),
    .i_waddr  (r_rd),
    .i_wdata  (r_wdata),
    .i_raddr1 (bus.raddr1),
    .i_raddr2 (bus.raddr2),
    .o_rdata1 (w_gpr_rd1),
    .o_rdata2 (w_gpr_rd2)
  );

  // Read ports: pending write data overrides the array for a matching index.
  always_comb begin
    bus.rdata1 = w_gpr_rd1;
    bus.rdata2 = w_gpr_rd2;
    if (r_busy && r_wr_pend && (bus.raddr1 == r_rd)) bus.rdata1 = r_wdata;
    else bus.rdata1 = w_gpr_rd1;
    if (r_busy && r_wr_pend && (bus.raddr2 == r_rd)) bus.rdata2 = r_wdata;
    else bus.rdata2 = w_gpr_rd2;
  end
endmodule

// File: tb/tb_wbu_gpr.sv
// Directed self-checking bench for the write-back stage.
module tb_wbu_gpr;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  wbu_gpr_if bus ();

  wbu_gpr #(.NR_REG(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] cond,
                       input logic [4:0] rd, input logic wen, input logic [31:0] data,
                       input logic [31:0] pc, input logic [31:0] imm);
    bus.in_valid = v;
    bus.wb_op    = op;
    bus.br_cond  = cond;
    bus.rd       = rd;
    bus.wen      = wen;
    bus.exu_data = data;
    bus.pc       = pc;
    bus.imm      = imm;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 3'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    bus.out_ready = 1'b0;
    bus.raddr1 = 5'd0;
    bus.raddr2 = 5'd0;
    tick();
    tick();
    rst_n = 1'b1;
    bus.raddr1 = 5'd5;
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_br_taken", {31'b0, bus.br_taken}, 32'd0);
    chk("rst_next_pc", bus.next_pc, 32'h0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_x5", bus.rdata1, 32'h0);

    // pass op to x5
    bus.out_ready = 1'b1;
    drive(1'b1, 2'd0, 3'd0, 5'd5, 1'b1, 32'hDEADBEEF, 32'h0000_0100, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("op0_out_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("op0_next_pc", bus.next_pc, 32'h0000_0104);
    chk("op0_br_taken", {31'b0, bus.br_taken}, 32'd0);
    chk("op0_fwd_x5", bus.rdata1, 32'hDEADBEEF);
    tick();
    chk("op0_x5", bus.rdata1, 32'hDEADBEEF);
    chk("op0_drained", {31'b0, bus.out_valid}, 32'd0);

    // set-less-than into x3: less -> 1, then greater -> 0
    bus.raddr1 = 5'd3;
    drive(1'b1, 2'd1, 3'd0, 5'd3, 1'b1, 32'h4, 32'h0000_0200, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("slt_lt_x3", bus.rdata1, 32'h1);
    drive(1'b1, 2'd1, 3'd0, 5'd3, 1'b1, 32'h2, 32'h0000_0204, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("slt_gt_x3", bus.rdata1, 32'h0);

    // blt taken then not taken, back-to-back; rd=9 must not be written
    bus.raddr2 = 5'd9;
    drive(1'b1, 2'd2, 3'd4, 5'd9, 1'b1, 32'h4, 32'h8000_0000, 32'hFFFF_FFF0);
    tick();
    bus.exu_data = 32'h2;
    #1;
    chk("blt_taken", {31'b0, bus.br_taken}, 32'd1);
    chk("blt_taken_pc", bus.next_pc, 32'h7FFF_FFF0);
    chk("blt_b2b_ready", {31'b0, bus.in_ready}, 32'd1);
    tick();
    chk("blt_nt", {31'b0, bus.br_taken}, 32'd0);
    chk("blt_nt_pc", bus.next_pc, 32'h8000_0004);
    chk("blt_b2b_valid", {31'b0, bus.out_valid}, 32'd1);
    // beq taken, then unknown condition not taken
    drive(1'b1, 2'd2, 3'd0, 5'd9, 1'b1, 32'h0, 32'h0000_1000, 32'h0000_0020);
    tick();
    chk("beq_pc", bus.next_pc, 32'h0000_1020);
    drive(1'b1, 2'd2, 3'd3, 5'd9, 1'b1, 32'h0, 32'h0000_1000, 32'h0000_0020);
    tick();
    chk("bcond3_pc", bus.next_pc, 32'h0000_1004);
    chk("bcond3_taken", {31'b0, bus.br_taken}, 32'd0);
    // bge with greater: taken
    drive(1'b1, 2'd2, 3'd5, 5'd9, 1'b1, 32'h2, 32'h0000_2000, 32'h0000_0100);
    tick();
    bus.in_valid = 1'b0;
    chk("bge_pc", bus.next_pc, 32'h0000_2100);
    tick();
    chk("branch_no_wr_x9", bus.rdata2, 32'h0);

    // stall: out_ready low for 3 cycles with a second entry waiting
    bus.out_ready = 1'b0;
    bus.raddr1 = 5'd6;
    drive(1'b1, 2'd0, 3'd0, 5'd6, 1'b1, 32'h0000_55AA, 32'h0000_0200, 32'h0);
    tick();
    drive(1'b1, 2'd0, 3'd0, 5'd6, 1'b1, 32'h0000_0077, 32'h0000_0300, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("stall_next_pc", bus.next_pc, 32'h0000_0204);
      chk("stall_fwd_x6", bus.rdata1, 32'h0000_55AA);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("stall_second_pc", bus.next_pc, 32'h0000_0304);
    chk("stall_second_fwd", bus.rdata1, 32'h0000_0077);
    tick();
    chk("stall_x6_final", bus.rdata1, 32'h0000_0077);

    // write to x0 is dropped
    bus.raddr1 = 5'd0;
    drive(1'b1, 2'd0, 3'd0, 5'd0, 1'b1, 32'h0000_1234, 32'h0, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("x0_pending", bus.rdata1, 32'h0);
    tick();
    chk("x0_after", bus.rdata1, 32'h0);

    // held pending write to x7 forwarded on port 2
    bus.out_ready = 1'b0;
    bus.raddr2 = 5'd7;
    drive(1'b1, 2'd0, 3'd0, 5'd7, 1'b1, 32'h0000_CAFE, 32'h0, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("fwd_x7", bus.rdata2, 32'h0000_CAFE);
    tick();
    chk("fwd_x7_held", bus.rdata2, 32'h0000_CAFE);
    bus.out_ready = 1'b1;
    tick();
    chk("x7_written", bus.rdata2, 32'h0000_CAFE);

    // reset while a write is pending
    bus.out_ready = 1'b0;
    bus.raddr1 = 5'd10;
    bus.raddr2 = 5'd5;
    drive(1'b1, 2'd0, 3'd0, 5'd10, 1'b1, 32'h0000_ABCD, 32'h0000_0400, 32'h0);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("pre_rst_busy", {31'b0, bus.out_valid}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("mid_rst_next_pc", bus.next_pc, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("mid_rst_x10", bus.rdata1, 32'h0);
    chk("mid_rst_x5", bus.rdata2, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wbu_gpr.md
WBU_GPR -- requirements
Module: wbu_gpr

Interface
REQ-001 SHALL have parameter: NR_REG, 32, number of architectural GPRs (16 for RV32E builds).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  EXU result valid.
REQ-005 SHALL have port: in_ready  output  1  stage can accept a result.
REQ-006 SHALL have port: exu_data  input  32  EXU result; for compares: 0 equal, 32'h2 greater, 32'h4 less.
REQ-007 SHALL have port: wb_op  input  2  0 pass, 1 set-less-than, 2 branch, 3 no writeback.
REQ-008 SHALL have port: br_cond  input  3  0 eq, 1 ne, 4 lt, 5 ge (signedness already chosen by EXU mode).
REQ-009 SHALL have ports: rd  input  5, and wen  input  1, giving destination index and write enable.
REQ-010 SHALL have ports: pc  input  32, and imm  input  32, giving the instruction PC and branch offset.
REQ-011 SHALL have ports: raddr1/raddr2  input  5 each, and rdata1/rdata2  output  32 each; these drive EXU operands.
REQ-012 SHALL have ports: out_valid  output  1, out_ready  input  1, next_pc  output  32, and br_taken  output  1.

Function
REQ-013 SHALL accept an entry when in_valid && in_ready, capturing all inputs into a one-entry stage register and setting busy.
REQ-014 SHALL drive out_valid = busy and in_ready = !busy || out_ready (combinational).
REQ-015 SHALL commit on out_valid && out_ready: perform the GPR write, then clear busy unless a new entry is accepted in the same cycle.
REQ-016 SHALL, on simultaneous commit and accept, write the old entry and load the new one, sustaining 1 result/cycle.
REQ-017 SHALL write the GPR only if wen=1, rd!=0, rd<NR_REG and wb_op is 0 or 1.
REQ-018 SHALL use write data exu_data for op 0, and {31'b0, exu_data==32'h4} for op 1.
REQ-019 SHALL compute taken for op 2 as: eq exu_data==0; ne !=0; lt ==32'h4; ge !=32'h4; other br_cond not taken.
REQ-020 SHALL drive br_taken = taken, and next_pc = taken ? pc+imm : pc+4, modulo 2^32; br_taken=0 for ops 0, 1, 3.
REQ-021 SHALL hold next_pc and br_taken stable while out_valid && !out_ready.
REQ-022 SHALL return 0 on reads of index 0 or index >= NR_REG.
REQ-023 SHALL forward pending data to rdata when busy, a write is pending and raddr==pending rd; otherwise return array contents.
REQ-024 SHALL make read ports combinational (zero latency), and make a committed write visible from the next cycle.

Reset
REQ-025 SHALL, while rst_n=0 at an edge, clear busy, out_valid, br_taken, next_pc (to 0) and all GPRs.
REQ-026 SHALL drive in_ready=1 in the first cycle after reset.
REQ-027 SHALL, on reset mid-operation, discard the pending entry with no GPR write.

Structure
REQ-028 SHALL place the wb_op encodings, br_cond encodings and compare codes (CMP_EQ=0, CMP_GT=2, CMP_LT=4) in the shared npc package.
REQ-029 SHALL instantiate sub-module gpr_file: NR_REG x 32, two async read ports, one sync write port, x0 hardwired zero.

Verification
REQ-030 SHALL cover: op0, rd=5, exu_data=32'hDEADBEEF, out_ready=1 -> next cycle raddr1=5 reads 32'hDEADBEEF; next_pc=pc+4.
REQ-031 SHALL cover: op1, exu_data=32'h4, then 32'h2, rd=3 -> x3=1, then x3=0.
REQ-032 SHALL cover: op2 blt, pc=32'h80000000, imm=32'hFFFFFFF0, exu_data=4 -> br_taken=1, next_pc=32'h7FFFFFF0; exu_data=2 -> next_pc=32'h80000004.
REQ-033 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, one write only after out_ready=1.
REQ-034 SHALL cover: write to rd=0 with data 32'h1234 -> x0 reads 0; pending rd=7 held busy -> raddr2=7 returns forwarded value.
REQ-035 SHALL cover: rst_n=0 while busy with wen=1 -> out_valid=0, target register still 0, in_ready=1 next cycle.
